seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter MAX_LEN SHALL exist: default 8; maximum pattern length in bits.
REQ-002 Parameter CNT_W SHALL exist: default 4; width of the repeat count.
REQ-003 Parameter GAP SHALL exist: default 0; idle cycles inserted between repetitions.
REQ-004 Port clk SHALL be: input, 1 bit; the single clock; all state changes on posedge.
REQ-005 Port reset SHALL be: input, 1 bit; asynchronous, active-high.
REQ-006 Port start SHALL be: input, 1 bit; request to begin a transmission, sampled only in IDLE.
REQ-007 Port pattern SHALL be: input, MAX_LEN bits; the bits to send, right-justified, sent MSB-first from bit pat_len-1.
REQ-008 Port pat_len SHALL be: input, $clog2(MAX_LEN+1) bits; number of pattern bits to send.
REQ-009 Port repeat_cnt SHALL be: input, CNT_W bits; number of pattern repetitions.
REQ-010 Port abort SHALL be: input, 1 bit; synchronous cancel of the current transmission.
REQ-011 Port out_bit SHALL be: output, 1 bit; the serial data bit.
REQ-012 Port out_valid SHALL be: output, 1 bit; out_bit carries a pattern bit this cycle.
REQ-013 Port busy SHALL be: output, 1 bit; the transmitter is not in IDLE.
REQ-014 Port done SHALL be: output, 1 bit; one-cycle pulse on normal completion.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, GAP and DONE; all outputs SHALL be registered.
REQ-016 IDLE SHALL, on start=1 with pat_len!=0, capture pattern, pat_len and repeat_cnt and go to SHIFT; inputs SHALL be ignored thereafter until IDLE is reached again.
REQ-017 Latency SHALL be fixed: first bit appears with out_valid=1 in the cycle after start is sampled.
REQ-018 SHIFT SHALL emit exactly one bit per cycle, in order pattern[len-1] down to pattern[0].
REQ-019 After the last bit of a repetition, the FSM SHALL go to GAP if GAP>0 and more repetitions remain, to SHIFT if GAP=0 and more remain (back-to-back, no bubble), else to DONE.
REQ-020 GAP SHALL hold out_valid=0 and out_bit=0 for exactly GAP cycles, then return to SHIFT.
REQ-021 DONE SHALL assert done=1 and busy=1 for exactly one cycle, then go to IDLE.
REQ-022 busy SHALL be 1 from the first-bit cycle through the DONE cycle inclusive.
REQ-023 out_bit SHALL be 0 whenever out_valid=0.
REQ-024 Boundary: start with pat_len=0 SHALL be ignored (remain IDLE, busy stays 0).
REQ-025 Boundary: pat_len>MAX_LEN SHALL be clamped to MAX_LEN at capture.
REQ-026 Boundary: repeat_cnt=0 SHALL be treated as 1.
REQ-027 Boundary: start while busy SHALL be ignored, with no queueing.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with out_valid=0, busy=0 and no done pulse.
REQ-029 abort SHALL take priority over all other transitions, including the transition into DONE.
REQ-030 Counters SHALL saturate nowhere: the bit index counts down from len-1 and wraps only on reload per repetition.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, including mid-transmission.
REQ-032 reset=1 SHALL immediately drive out_bit=0, out_valid=0, busy=0 and done=0.
REQ-033 reset=1 SHALL immediately clear the captured pattern and all counters.
REQ-034 Release of reset SHALL NOT produce a done pulse or spurious out_valid.

Structure
REQ-035 Package seq_pkg SHALL hold the state encoding typedef (IDLE=0, SHIFT=1, GAP=2, DONE=3).
REQ-036 Package seq_pkg SHALL hold the default MAX_LEN constant.
REQ-037 A sub-module seq_shift_reg SHALL be used: a loadable MAX_LEN-bit left shift register with selectable start bit, driving out_bit.

Verification
REQ-038 Basic: pattern=4'b1011, pat_len=4, repeat_cnt=1, GAP=0 -> out_bit 1,0,1,1 on cycles 1-4 after start, done on cycle 5, busy high cycles 1-5.
REQ-039 Repeat: same pattern, repeat_cnt=3, GAP=0 -> 12 contiguous valid bits 1011 1011 1011, done on cycle 13; with GAP=2 -> 2 invalid cycles between groups, done on cycle 17.
REQ-040 Edge inputs: pat_len=0 start -> busy never asserts; pat_len=12 with MAX_LEN=8 -> 8 bits sent; repeat_cnt=0 -> one repetition.
REQ-041 Abort: abort asserted on the 3rd bit cycle -> out_valid=0 and busy=0 the next cycle, done never pulses; a new start two cycles later transmits correctly.
REQ-042 Reset mid-operation: reset asserted between edges during SHIFT -> outputs 0 immediately without waiting for clk; first start after release behaves as in REQ-038.
REQ-043 Busy start: start pulsed with pattern=8'hFF during a transmission -> ignored; the original pattern completes unchanged.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and FSM state encoding for the pattern transmitter
package seq_pkg;

    localparam int SEQ_MAX_LEN = 8;
    localparam int SEQ_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - request and serial output signals of the pattern transmitter
interface seq_pattern_tx_if
    import seq_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = SEQ_CNT_W
);

    logic                         start;
    logic [MAX_LEN-1:0]           pattern;
    logic [$clog2(MAX_LEN+1)-1:0] pat_len;
    logic [CNT_W-1:0]             repeat_cnt;
    logic                         abort;
    logic                         out_bit;
    logic                         out_valid;
    logic                         busy;
    logic                         done;

    modport master (
        output start, pattern, pat_len, repeat_cnt, abort,
        input  out_bit, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, pat_len, repeat_cnt, abort,
        output out_bit, out_valid, busy, done
    );

endinterface

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - loadable left shift register; the selected start bit is aligned to the MSB on load
module seq_shift_reg #(
    parameter int MAX_LEN = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         shift,
    input  logic                         clear,
    input  logic [MAX_LEN-1:0]           load_data,
    input  logic [$clog2(MAX_LEN+1)-1:0] start_bit,
    output logic                         out_bit
);

    localparam int W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] sh;
    logic [W-1:0]       shamt;

    // Left-justifying drops the bits above start_bit, so after the last
    // pattern bit shifts out the register is zero and out_bit idles low.
    assign shamt = W'(MAX_LEN - 1) - start_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else if (clear) begin
            sh <= '0;
        end else if (load) begin
            sh <= load_data << shamt;
        end else if (shift) begin
            sh <= sh << 1;
        end
    end

    assign out_bit = sh[MAX_LEN-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter with repeat count, inter-repetition gap and abort
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN,
    parameter int CNT_W   = SEQ_CNT_W,
    parameter int GAP     = 0
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_tx_if.slave  bus
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_t             state, state_nx;
    logic [MAX_LEN-1:0] cap_pattern, cap_pattern_nx;
    logic [LEN_W-1:0]   cap_len, cap_len_nx;
    logic [LEN_W-1:0]   bit_idx, bit_idx_nx;
    logic [CNT_W-1:0]   rep_left, rep_left_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
    logic               out_valid_q, busy_q, done_q;
    logic               valid_nx, busy_nx, done_nx;
    logic               sr_load, sr_shift, sr_clear;
    logic [MAX_LEN-1:0] sr_data;
    logic [LEN_W-1:0]   sr_start;
    logic [LEN_W-1:0]   len_in;

    assign len_in = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cap_pattern_nx = cap_pattern;
        cap_len_nx     = cap_len;
        bit_idx_nx     = bit_idx;
        rep_left_nx    = rep_left;
        gap_cnt_nx     = gap_cnt;
        valid_nx       = 1'b0;
        busy_nx        = 1'b0;
        done_nx        = 1'b0;
        sr_load        = 1'b0;
        sr_shift       = 1'b0;
        sr_clear       = 1'b0;
        sr_data        = cap_pattern;
        sr_start       = cap_len - LEN_W'(1);

        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.pat_len != '0)) begin
                    cap_pattern_nx = bus.pattern;
                    cap_len_nx     = len_in;
                    rep_left_nx    = (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
                    bit_idx_nx     = len_in - LEN_W'(1);
                    sr_load        = 1'b1;
                    sr_data        = bus.pattern;
                    sr_start       = len_in - LEN_W'(1);
                    state_nx       = ST_SHIFT;
                    valid_nx       = 1'b1;
                    busy_nx        = 1'b1;
                end
            end
            ST_SHIFT: begin
                busy_nx = 1'b1;
                if (bit_idx != '0) begin
                    bit_idx_nx = bit_idx - LEN_W'(1);
                    sr_shift   = 1'b1;
                    valid_nx   = 1'b1;
                end else if (rep_left > CNT_W'(1)) begin
                    rep_left_nx = rep_left - CNT_W'(1);
                    if (GAP > 0) begin
                        state_nx   = ST_GAP;
                        gap_cnt_nx = GAP_W'(GAP - 1);
                        sr_shift   = 1'b1;
                    end else begin
                        // back-to-back repetition: reload without a bubble
                        sr_load    = 1'b1;
                        bit_idx_nx = cap_len - LEN_W'(1);
                        valid_nx   = 1'b1;
                    end
                end else begin
                    state_nx = ST_DONE;
                    sr_shift = 1'b1;
                    done_nx  = 1'b1;
                end
            end
            ST_GAP: begin
                busy_nx = 1'b1;
                if (gap_cnt == '0) begin
                    state_nx   = ST_SHIFT;
                    sr_load    = 1'b1;
                    bit_idx_nx = cap_len - LEN_W'(1);
                    valid_nx   = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // abort wins over every transition, including the one into DONE
        if (bus.abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
            sr_load  = 1'b0;
            sr_shift = 1'b0;
            sr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_pattern <= '0;
            cap_len     <= '0;
            bit_idx     <= '0;
            rep_left    <= '0;
            gap_cnt     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cap_pattern <= cap_pattern_nx;
            cap_len     <= cap_len_nx;
            bit_idx     <= bit_idx_nx;
            rep_left    <= rep_left_nx;
            gap_cnt     <= gap_cnt_nx;
            out_valid_q <= valid_nx;
            busy_q      <= busy_nx;
            done_q      <= done_nx;
        end
    end

    seq_shift_reg #(
        .MAX_LEN (MAX_LEN)
    ) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .shift     (sr_shift),
        .clear     (sr_clear),
        .load_data (sr_data),
        .start_bit (sr_start),
        .out_bit   (bus.out_bit)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx with GAP=0 and GAP=2 instances
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int MAX_LEN = SEQ_MAX_LEN;
    localparam int CNT_W   = SEQ_CNT_W;

    typedef logic [3:0] obs_t;   // {out_valid, out_bit, busy, done}
    typedef obs_t obs_q_t[$];

    typedef struct {
        logic [7:0] pattern;
        logic [3:0] pat_len;
        logic [3:0] repeat_cnt;
        int         abort_at;
        int         busy_start_at;
        int         exp_done0;
        int         exp_done2;
        int         exp_bits0;
        int         exp_bits2;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) if0 ();
    seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) if2 ();

    seq_pattern_tx #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .GAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    seq_pattern_tx #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .GAP(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic st, input logic [7:0] pat, input logic [3:0] plen,
                         input logic [3:0] rep, input logic ab);
        if0.start = st; if0.pattern = pat; if0.pat_len = plen; if0.repeat_cnt = rep; if0.abort = ab;
        if2.start = st; if2.pattern = pat; if2.pat_len = plen; if2.repeat_cnt = rep; if2.abort = ab;
    endtask

    task automatic set_abort(input logic ab);
        if0.abort = ab;
        if2.abort = ab;
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {valid,bit,busy,done}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected per-cycle output list of one transmission, cycle 1 = first cycle after start.
    task automatic build_model(input logic [7:0] pat, input int plen, input int rep,
                               input int gap, output obs_q_t q);
        int len;
        int reps;
        q    = {};
        len  = (plen > MAX_LEN) ? MAX_LEN : plen;
        reps = (rep == 0) ? 1 : rep;
        if (len == 0) return;
        for (int r = 0; r < reps; r++) begin
            for (int i = len - 1; i >= 0; i--) q.push_back({1'b1, pat[i], 1'b1, 1'b0});
            if (r < reps - 1) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
        end
        q.push_back(4'b0011);
    endtask

    function automatic obs_t exp_at(input obs_q_t q, input int c, input int abort_at);
        if (abort_at > 0 && c > abort_at) return 4'b0000;
        if (c <= q.size()) return q[c-1];
        return 4'b0000;
    endfunction

    task automatic run_vec(input vec_t v, input string tag, input bit tally_chk);
        obs_q_t q0, q2;
        int     win, done0, done2, bits0, bits2;
        obs_t   a0, a2;
        build_model(v.pattern, int'(v.pat_len), int'(v.repeat_cnt), 0, q0);
        build_model(v.pattern, int'(v.pat_len), int'(v.repeat_cnt), 2, q2);
        win = (v.abort_at > 0) ? v.abort_at + 1
                               : ((q0.size() > q2.size()) ? q0.size() : q2.size()) + 1;
        if (win < 3) win = 3;
        done0 = 0; done2 = 0; bits0 = 0; bits2 = 0;

        @(negedge clk);
        drive(1'b1, v.pattern, v.pat_len, v.repeat_cnt, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 8'($urandom), 4'($urandom), 4'($urandom), 1'b0);
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            a0 = {if0.out_valid, if0.out_bit, if0.busy, if0.done};
            a2 = {if2.out_valid, if2.out_bit, if2.busy, if2.done};
            check($sformatf("%s cyc%0d gap0", tag, c), a0, exp_at(q0, c, v.abort_at));
            check($sformatf("%s cyc%0d gap2", tag, c), a2, exp_at(q2, c, v.abort_at));
            if (a0[3]) bits0++;
            if (a2[3]) bits2++;
            if (a0[0] && done0 == 0) done0 = c;
            if (a2[0] && done2 == 0) done2 = c;
            set_abort(c == v.abort_at);
            if (c == v.busy_start_at) drive(1'b1, 8'hFF, 4'd8, 4'd1, 1'b0);
            else begin
                if0.start = 1'b0;
                if2.start = 1'b0;
            end
        end
        drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
        if (tally_chk) begin
            check_int({tag, " done_cycle gap0"}, done0, v.exp_done0);
            check_int({tag, " done_cycle gap2"}, done2, v.exp_done2);
            check_int({tag, " valid_bits gap0"}, bits0, v.exp_bits0);
            check_int({tag, " valid_bits gap2"}, bits2, v.exp_bits2);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " gap0"}, {if0.out_valid, if0.out_bit, if0.busy, if0.done}, 4'b0000);
        check({name, " gap2"}, {if2.out_valid, if2.out_bit, if2.busy, if2.done}, 4'b0000);
    endtask

    vec_t vecs[10];

    initial begin
        //          pattern  len    rep    abort busyst d0  d2  b0  b2
        vecs[0] = '{8'h0B,  4'd4,  4'd1,  0,    0,     5,  5,  4,  4};
        vecs[1] = '{8'h0B,  4'd4,  4'd3,  0,    0,     13, 17, 12, 12};
        vecs[2] = '{8'hA5,  4'd12, 4'd1,  0,    0,     9,  9,  8,  8};
        vecs[3] = '{8'h06,  4'd3,  4'd0,  0,    0,     4,  4,  3,  3};
        vecs[4] = '{8'hFF,  4'd0,  4'd1,  0,    0,     0,  0,  0,  0};
        vecs[5] = '{8'h0B,  4'd4,  4'd1,  3,    0,     0,  0,  3,  3};
        vecs[6] = '{8'h0B,  4'd4,  4'd1,  0,    0,     5,  5,  4,  4};
        vecs[7] = '{8'h0B,  4'd4,  4'd2,  0,    2,     9,  11, 8,  8};
        vecs[8] = '{8'h01,  4'd1,  4'd2,  0,    0,     3,  5,  2,  2};
        vecs[9] = '{8'h0B,  4'd4,  4'd3,  6,    0,     0,  0,  6,  4};

        drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
        reset = 1'b0;
        #1 reset = 1'b1;
        #1 check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // abort on the last bit: must not reach DONE
        begin
            vec_t va;
            va = '{8'h0B, 4'd4, 4'd1, 4, 0, 0, 0, 4, 4};
            run_vec(va, "abort_last", 1'b1);
        end

        // asynchronous reset between edges while shifting
        @(negedge clk);
        drive(1'b1, 8'h0B, 4'd4, 4'd1, 1'b0);
        @(posedge clk);
        #1 if0.start = 1'b0; if2.start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset_mid_shift");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_all_zero($sformatf("after_reset_release%0d", c));
        end
        run_vec(vecs[0], "after_reset_basic", 1'b1);

        // randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            vec_t   vr;
            obs_q_t qr;
            int     mode;
            vr.pattern       = 8'($urandom);
            vr.pat_len       = 4'($urandom_range(0, 10));
            vr.repeat_cnt    = 4'($urandom_range(0, 3));
            vr.abort_at      = 0;
            vr.busy_start_at = 0;
            vr.exp_done0 = 0; vr.exp_done2 = 0; vr.exp_bits0 = 0; vr.exp_bits2 = 0;
            build_model(vr.pattern, int'(vr.pat_len), int'(vr.repeat_cnt), 0, qr);
            mode = $urandom_range(0, 3);
            if (qr.size() > 0) begin
                if (mode == 1) vr.abort_at = $urandom_range(1, qr.size());
                else if (mode == 2) vr.busy_start_at = $urandom_range(1, qr.size());
            end
            run_vec(vr, $sformatf("rnd%0d", n), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
